// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the button_debounce block.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // Counter width able to hold 0..cycles-1, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM, registered level and
// press/release pulses. Long-press detection is present only when
// BUTTON_DEBOUNCE_HOLD_EN is defined; otherwise hold_pulse is tied low.
//
// state        | meaning
// RELEASED     | accepted level is released, waiting for a press
// PRESS_WAIT   | press seen, counting the stable window
// PRESSED      | accepted level is pressed, waiting for a release
// RELEASE_WAIT | release seen, counting the stable window
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic stable,
  output logic press_next,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           REL_LVL  = (ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_param_check
    $error("debounce_channel: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 2");
  end

  logic          sync1, sync2, p;
  db_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          release_n, stable_n;

  // Two-flop synchroniser; reset loads the released pin level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= REL_LVL;
      sync2 <= REL_LVL;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  assign p = sync2 ^ REL_LVL;

  // Next-state, window counter and event decode.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    press_next = 1'b0;
    release_n  = 1'b0;
    case (state)
      RELEASED: begin
        if (p) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n    = PRESSED;
          cnt_n      = '0;
          press_next = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = RELEASED;
          cnt_n     = '0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = RELEASED;
        cnt_n   = '0;
      end
    endcase
    stable_n = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RELEASED;
      cnt           <= '0;
      stable        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      stable        <= stable_n;
      press_pulse   <= press_next;
      release_pulse <= release_n;
    end
  end

`ifdef BUTTON_DEBOUNCE_HOLD_EN
  localparam int             HW        = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic          hold_done;

  // Long-press timer: runs only while staying in PRESSED, fires once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      hold_done  <= 1'b0;
      hold_pulse <= 1'b0;
    end else begin
      hold_pulse <= 1'b0;
      if (state == PRESSED && state_n == PRESSED) begin
        if (!hold_done) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_pulse <= 1'b1;
            hold_done  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
      end else begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
      end
    end
  end
`else
  assign hold_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Debounced push-button conditioning for the HPS button PIO.
// Optional long-press pulses: define BUTTON_DEBOUNCE_HOLD_EN.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 8,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic                 clk_clk_clk,
  input  logic                 reset_reset_n,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_stable,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] hold_pulse,
  output logic [CNT_W-1:0]     press_count
);

  logic [N_BUTTONS-1:0] press_next;
  logic [CNT_W-1:0]     press_inc;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .clk           (clk_clk_clk),
      .rst_n         (reset_reset_n),
      .pin           (btn_raw[i]),
      .stable        (btn_stable[i]),
      .press_next    (press_next[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .hold_pulse    (hold_pulse[i])
    );
  end

  // Popcount of presses accepted this cycle, so simultaneous presses all count.
  always_comb begin
    press_inc = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      press_inc = press_inc + CNT_W'(press_next[i]);
    end
  end

  // Wrapping press tally, updated on the same edge as press_pulse.
  always_ff @(posedge clk_clk_clk) begin
    if (!reset_reset_n) begin
      press_count <= '0;
    end else begin
      press_count <= press_count + press_inc;
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (DEBOUNCE_CYCLES=8, HOLD_CYCLES=20).
module tb_button_debounce;

`ifdef BUTTON_DEBOUNCE_HOLD_EN
  localparam logic HOLD_EXP = 1'b1;
`else
  localparam logic HOLD_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] raw;
  logic [1:0] stable, pp, rp, hp;
  logic [7:0] cnt;

  int         n_vec = 0;
  int         n_err = 0;
  int         pc0 = 0, rc0 = 0, hc0 = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  button_debounce #(
    .N_BUTTONS       (2),
    .DEBOUNCE_CYCLES (8),
    .ACTIVE_LOW      (1),
    .CNT_W           (8),
    .HOLD_CYCLES     (20)
  ) dut (
    .clk_clk_clk   (clk),
    .reset_reset_n (rst_n),
    .btn_raw       (raw),
    .btn_stable    (stable),
    .press_pulse   (pp),
    .release_pulse (rp),
    .hold_pulse    (hp),
    .press_count   (cnt)
  );

  always @(negedge clk) begin
    if (pp[0]) pc0++;
    if (rp[0]) rc0++;
    if (hp[0]) hc0++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; raw = 2'b11;
    tick(3);
    n_vec++; if (stable !== 2'b00) begin n_err++; $display("FAIL rst_stable: got %b want 00", stable); end
    n_vec++; if (pp !== 2'b00) begin n_err++; $display("FAIL rst_press: got %b want 00", pp); end
    n_vec++; if (rp !== 2'b00) begin n_err++; $display("FAIL rst_release: got %b want 00", rp); end
    n_vec++; if (hp !== 2'b00) begin n_err++; $display("FAIL rst_hold: got %b want 00", hp); end
    n_vec++; if (cnt !== 8'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", cnt); end
    rst_n = 1'b1;
    tick(3);
    n_vec++; if (stable !== 2'b00) begin n_err++; $display("FAIL post_rst_stable: got %b want 00", stable); end
  endtask

  task automatic test_clean_press;
    raw[0] = 1'b0;
    tick(10);
    n_vec++; if (pp !== 2'b00) begin n_err++; $display("FAIL press_early: got %b want 00", pp); end
    n_vec++; if (stable !== 2'b00) begin n_err++; $display("FAIL stable_early: got %b want 00", stable); end
    tick(1);
    exp_cnt = exp_cnt + 8'd1;
    n_vec++; if (pp !== 2'b01) begin n_err++; $display("FAIL press_edge: got %b want 01", pp); end
    n_vec++; if (stable !== 2'b01) begin n_err++; $display("FAIL stable_edge: got %b want 01", stable); end
    n_vec++; if (cnt !== exp_cnt) begin n_err++; $display("FAIL press_count1: got %0d want %0d", cnt, exp_cnt); end
    tick(1);
    n_vec++; if (pp !== 2'b00) begin n_err++; $display("FAIL press_width: got %b want 00", pp); end
  endtask

  task automatic test_hold;
    int h0;
    h0 = hc0;
    tick(18);
    n_vec++; if (hp !== 2'b00) begin n_err++; $display("FAIL hold_early: got %b want 00", hp); end
    tick(1);
    n_vec++; if (hp[0] !== HOLD_EXP) begin n_err++; $display("FAIL hold_edge: got %b want %b", hp[0], HOLD_EXP); end
    tick(20);
    n_vec++; if (hc0 - h0 !== int'(HOLD_EXP)) begin n_err++; $display("FAIL hold_count: got %0d want %0d", hc0 - h0, int'(HOLD_EXP)); end
    n_vec++; if (stable !== 2'b01) begin n_err++; $display("FAIL hold_stable: got %b want 01", stable); end
  endtask

  task automatic test_release;
    int r0;
    r0 = rc0;
    raw[0] = 1'b1;
    tick(3);
    raw[0] = 1'b0;
    tick(15);
    n_vec++; if (rc0 !== r0) begin n_err++; $display("FAIL glitch_release: got %0d pulses want 0", rc0 - r0); end
    n_vec++; if (stable !== 2'b01) begin n_err++; $display("FAIL glitch_stable: got %b want 01", stable); end
    raw[0] = 1'b1;
    tick(10);
    n_vec++; if (rp !== 2'b00) begin n_err++; $display("FAIL release_early: got %b want 00", rp); end
    tick(1);
    n_vec++; if (rp !== 2'b01) begin n_err++; $display("FAIL release_edge: got %b want 01", rp); end
    n_vec++; if (stable !== 2'b00) begin n_err++; $display("FAIL release_stable: got %b want 00", stable); end
    n_vec++; if (pp !== 2'b00) begin n_err++; $display("FAIL release_no_press: got %b want 00", pp); end
    tick(1);
    n_vec++; if (rp !== 2'b00) begin n_err++; $display("FAIL release_width: got %b want 00", rp); end
    tick(2);
    n_vec++; if (rc0 - r0 !== 1) begin n_err++; $display("FAIL release_total: got %0d want 1", rc0 - r0); end
  endtask

  task automatic test_bounce;
    int p0;
    p0 = pc0;
    raw[0] = 1'b0; tick(5);
    raw[0] = 1'b1; tick(1);
    raw[0] = 1'b0;
    tick(10);
    n_vec++; if (pp !== 2'b00) begin n_err++; $display("FAIL bounce_early: got %b want 00", pp); end
    n_vec++; if (pc0 !== p0) begin n_err++; $display("FAIL bounce_spurious: got %0d pulses want 0", pc0 - p0); end
    n_vec++; if (cnt !== exp_cnt) begin n_err++; $display("FAIL bounce_count_early: got %0d want %0d", cnt, exp_cnt); end
    tick(1);
    exp_cnt = exp_cnt + 8'd1;
    n_vec++; if (pp !== 2'b01) begin n_err++; $display("FAIL bounce_edge: got %b want 01", pp); end
    n_vec++; if (cnt !== exp_cnt) begin n_err++; $display("FAIL bounce_count: got %0d want %0d", cnt, exp_cnt); end
    tick(3);
    n_vec++; if (pc0 - p0 !== 1) begin n_err++; $display("FAIL bounce_total: got %0d want 1", pc0 - p0); end
    raw[0] = 1'b1;
    tick(14);
  endtask

  task automatic test_simultaneous;
    raw = 2'b00;
    tick(10);
    n_vec++; if (pp !== 2'b00) begin n_err++; $display("FAIL simul_early: got %b want 00", pp); end
    tick(1);
    exp_cnt = exp_cnt + 8'd2;
    n_vec++; if (pp !== 2'b11) begin n_err++; $display("FAIL simul_edge: got %b want 11", pp); end
    n_vec++; if (cnt !== exp_cnt) begin n_err++; $display("FAIL simul_count: got %0d want %0d", cnt, exp_cnt); end
    tick(1);
    n_vec++; if (pp !== 2'b00) begin n_err++; $display("FAIL simul_width: got %b want 00", pp); end
    raw = 2'b11;
    tick(14);
    n_vec++; if (stable !== 2'b00) begin n_err++; $display("FAIL simul_release: got %b want 00", stable); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 300; i++) begin
      if (exp_cnt == 8'd255) break;
      raw[0] = 1'b0; tick(11);
      exp_cnt = exp_cnt + 8'd1;
      raw[0] = 1'b1; tick(11);
    end
    n_vec++; if (cnt !== 8'd255) begin n_err++; $display("FAIL wrap_pre: got %0d want 255", cnt); end
    raw = 2'b00;
    tick(11);
    exp_cnt = exp_cnt + 8'd2;
    n_vec++; if (pp !== 2'b11) begin n_err++; $display("FAIL wrap_edge: got %b want 11", pp); end
    n_vec++; if (cnt !== 8'd1) begin n_err++; $display("FAIL wrap_count: got %0d want 1", cnt); end
    raw = 2'b11;
    tick(12);
  endtask

  task automatic test_reset_mid;
    int p0;
    raw[0] = 1'b0;
    tick(8);
    n_vec++; if (pp !== 2'b00) begin n_err++; $display("FAIL mid_pre: got %b want 00", pp); end
    p0 = pc0;
    rst_n = 1'b0;
    tick(3);
    exp_cnt = 8'd0;
    n_vec++; if (stable !== 2'b00) begin n_err++; $display("FAIL mid_rst_stable: got %b want 00", stable); end
    n_vec++; if (cnt !== exp_cnt) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", cnt); end
    rst_n = 1'b1;
    tick(10);
    n_vec++; if (pc0 !== p0) begin n_err++; $display("FAIL mid_spurious: got %0d pulses want 0", pc0 - p0); end
    n_vec++; if (pp !== 2'b00) begin n_err++; $display("FAIL mid_early: got %b want 00", pp); end
    tick(1);
    exp_cnt = exp_cnt + 8'd1;
    n_vec++; if (pp !== 2'b01) begin n_err++; $display("FAIL mid_edge: got %b want 01", pp); end
    n_vec++; if (stable !== 2'b01) begin n_err++; $display("FAIL mid_stable: got %b want 01", stable); end
    n_vec++; if (cnt !== exp_cnt) begin n_err++; $display("FAIL mid_count: got %0d want %0d", cnt, exp_cnt); end
    raw[0] = 1'b1;
    tick(14);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_hold();
    test_release();
    test_bounce();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
